// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if -- sequencer handshake/control bundle.
//   run            : step enable (0 = bubble)
//   ir_opcode[7:0] : instruction register contents
//   acc_neg        : accumulator sign flag
//   control_signal : registered 32-bit control word
//   state_o[3:0]   : current state (debug)
//   halted         : high while in HALT
// master drives the inputs and observes the outputs; slave is the sequencer.
interface micro_sequencer_if;
    logic        run;
    logic [7:0]  ir_opcode;
    logic        acc_neg;
    logic [31:0] control_signal;
    logic [3:0]  state_o;
    logic        halted;

    modport master (
        output run, ir_opcode, acc_neg,
        input  control_signal, state_o, halted
    );

    modport slave (
        input  run, ir_opcode, acc_neg,
        output control_signal, state_o, halted
    );
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer -- Moore micro-sequencer for a small accumulator machine.
// Walks fetch (F0..F2), decode, address (A0..A2) and execute (E0..E1) steps.
// Each step's control word is registered on entry, so control_signal comes
// straight from flops.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : micro_sequencer_if.slave (run, ir_opcode, acc_neg in;
//         control_signal, state_o, halted out)
module micro_sequencer (
    input  logic               clk,
    input  logic               rst,
    micro_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_A0   = 4'd5,
        S_A1   = 4'd6,
        S_A2   = 4'd7,
        S_E0   = 4'd8,
        S_E1   = 4'd9,
        S_HALT = 4'd10
    } state_t;

    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_STORE  = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMP    = 8'h05;
    localparam logic [7:0] OP_JMPGEZ = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'hFF;

    localparam logic [31:0] W_HALT = 32'h8000_0000;

    state_t      state;
    state_t      nxt;
    logic [7:0]  op;      // opcode captured when leaving DEC
    logic [31:0] ctrl;

    // Control word issued on entry to step s.
    function automatic logic [31:0] word(input state_t s, input logic [7:0] opc,
                                         input logic neg);
        logic [31:0] w;
        w = '0;
        case (s)
            S_F0, S_A0: w[2] = 1'b1;
            S_F1, S_A1: begin w[4] = 1'b1; w[20] = 1'b1; end
            S_F2:       w[5] = 1'b1;
            S_A2: begin
                if (opc == OP_JMP || (opc == OP_JMPGEZ && !neg)) w[3] = 1'b1;
                else if (opc != OP_JMPGEZ)                       w[6] = 1'b1;
            end
            S_E0: begin
                if (opc == OP_STORE) w[8] = 1'b1;
                else                 w[4] = 1'b1;
            end
            S_E1: begin
                case (opc)
                    OP_LOAD:  w[7]  = 1'b1;
                    OP_ADD:   w[9]  = 1'b1;
                    OP_SUB:   w[10] = 1'b1;
                    default:  w[0]  = 1'b1;  // STORE
                endcase
            end
            S_HALT:     w[31] = 1'b1;
            default:    w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = S_F0;
            S_F0:   nxt = S_F1;
            S_F1:   nxt = S_F2;
            S_F2:   nxt = S_DEC;
            S_DEC: begin
                if (bus.ir_opcode == OP_HALT)
                    nxt = S_HALT;
                else if (bus.ir_opcode >= OP_LOAD && bus.ir_opcode <= OP_JMPGEZ)
                    nxt = S_A0;
                else
                    nxt = S_F0;
            end
            S_A0:   nxt = S_A1;
            S_A1:   nxt = S_A2;
            S_A2:   nxt = (op == OP_JMP || op == OP_JMPGEZ) ? S_F0 : S_E0;
            S_E0:   nxt = S_E1;
            S_E1:   nxt = S_F0;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    // The A2 word is formed on the edge entering A2, so acc_neg is taken
    // there. A bubble zeroes the word but keeps the state, so on resume
    // the held step advances without repeating its word (no double PC_INC).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ctrl  <= '0;
            op    <= '0;
        end else if (state == S_HALT) begin
            ctrl <= W_HALT;
        end else if (bus.run) begin
            state <= nxt;
            ctrl  <= word(nxt, op, bus.acc_neg);
            if (state == S_DEC) op <= bus.ir_opcode;
        end else begin
            ctrl <= '0;
        end
    end

    assign bus.control_signal = ctrl;
    assign bus.state_o        = state;
    assign bus.halted         = (state == S_HALT);

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer -- directed bench for micro_sequencer.
// A queue model expands each instruction into its list of control words
// and is compared against the DUT every cycle; literal checks pin the
// model along the directed sequence.
module tb_micro_sequencer;

    logic clk;
    logic rst;
    micro_sequencer_if bus();

    micro_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // ---------------- model ----------------
    localparam int MK_DEC  = -1;
    localparam int MK_HALT = -2;
    int          q[$];
    logic [31:0] exp_cs = '0;
    bit          mhalt = 1'b0;
    int          w;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mhalt  = 1'b0;
            exp_cs = '0;
        end else if (mhalt) begin
            exp_cs = 32'h8000_0000;
        end else if (!bus.run) begin
            exp_cs = '0;
        end else begin
            if (q.size() == 0) begin
                q.push_back(32'h4); q.push_back(32'h10_0010);
                q.push_back(32'h20); q.push_back(MK_DEC);
            end
            w = q.pop_front();
            if (w == MK_DEC) begin
                exp_cs = '0;
                case (bus.ir_opcode)
                    8'h01: q = '{32'h4, 32'h10_0010, 32'h40, 32'h10, 32'h80};
                    8'h02: q = '{32'h4, 32'h10_0010, 32'h40, 32'h100, 32'h1};
                    8'h03: q = '{32'h4, 32'h10_0010, 32'h40, 32'h10, 32'h200};
                    8'h04: q = '{32'h4, 32'h10_0010, 32'h40, 32'h10, 32'h400};
                    8'h05: q = '{32'h4, 32'h10_0010, 32'h8};
                    8'h06: q = '{32'h4, 32'h10_0010, bus.acc_neg ? 32'h0 : 32'h8};
                    8'hFF: q = '{MK_HALT};
                    default: ;
                endcase
            end else if (w == MK_HALT) begin
                mhalt  = 1'b1;
                exp_cs = 32'h8000_0000;
            end else begin
                exp_cs = w;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (bus.control_signal !== exp_cs || bus.halted !== mhalt) begin
                n_err++;
                $display("FAIL model t=%0t: got cs=%h halted=%b expected cs=%h halted=%b",
                         $time, bus.control_signal, bus.halted, exp_cs, mhalt);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [31:0] exp);
        tick();
        lit(nm, bus.control_signal, exp);
    endtask

    // From F0: F1, F2, DEC words.
    task automatic fetch_rest(input string nm);
        step({nm, "_F1"}, 32'h10_0010);
        step({nm, "_F2"}, 32'h20);
        step({nm, "_DEC"}, 32'h0);
    endtask

    task automatic addr_ab(input string nm);
        step({nm, "_A0"}, 32'h4);
        step({nm, "_A1"}, 32'h10_0010);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        bus.run = 1'b0;
        bus.ir_opcode = 8'h00;
        bus.acc_neg = 1'b0;
        repeat (3) tick();
        lit("reset_cs", bus.control_signal, 32'h0);
        lit("reset_state", {28'h0, bus.state_o}, 32'h0);
        lit("reset_halted", {31'h0, bus.halted}, 32'h0);
        check_en = 1'b1;

        rst = 1'b1;
        bus.run = 1'b1;
        // NOP loop
        step("nop_F0", 32'h4);
        fetch_rest("nop");
        step("nop_F0b", 32'h4);

        // ADD
        bus.ir_opcode = 8'h03;
        fetch_rest("add");
        addr_ab("add");
        step("add_A2", 32'h40);
        step("add_E0", 32'h10);
        step("add_E1", 32'h200);
        step("add_F0", 32'h4);

        // JMPGEZ taken / not taken
        bus.ir_opcode = 8'h06; bus.acc_neg = 1'b0;
        fetch_rest("jgz0"); addr_ab("jgz0");
        step("jgz_taken_A2", 32'h8);
        step("jgz_taken_F0", 32'h4);
        bus.acc_neg = 1'b1;
        fetch_rest("jgz1"); addr_ab("jgz1");
        step("jgz_nt_A2", 32'h0);
        step("jgz_nt_F0", 32'h4);
        bus.acc_neg = 1'b0;

        // Unknown opcode runs as NOP
        bus.ir_opcode = 8'h42;
        fetch_rest("unk");
        step("unk_F0", 32'h4);

        // JMP, LOAD, SUB
        bus.ir_opcode = 8'h05;
        fetch_rest("jmp"); addr_ab("jmp");
        step("jmp_A2", 32'h8);
        step("jmp_F0", 32'h4);
        bus.ir_opcode = 8'h01;
        fetch_rest("load"); addr_ab("load");
        step("load_A2", 32'h40);
        step("load_E0", 32'h10);
        step("load_E1", 32'h80);
        step("load_F0", 32'h4);
        bus.ir_opcode = 8'h04;
        fetch_rest("sub"); addr_ab("sub");
        step("sub_A2", 32'h40);
        step("sub_E0", 32'h10);
        step("sub_E1", 32'h400);
        step("sub_F0", 32'h4);

        // Bubbles holding F0: three zero words, then F1 once
        bus.ir_opcode = 8'h00;
        bus.run = 1'b0;
        step("bub0", 32'h0);
        step("bub1", 32'h0);
        step("bub2", 32'h0);
        bus.run = 1'b1;
        step("bub_F1", 32'h10_0010);
        step("bub_F2", 32'h20);
        step("bub_DEC", 32'h0);
        step("bub_F0", 32'h4);

        // STORE aborted by reset in E0
        bus.ir_opcode = 8'h02;
        fetch_rest("st"); addr_ab("st");
        step("st_A2", 32'h40);
        step("st_E0", 32'h100);
        rst = 1'b0;
        #1;
        lit("st_rst_cs", bus.control_signal, 32'h0);
        lit("st_rst_state", {28'h0, bus.state_o}, 32'h0);
        step("st_rst_hold0", 32'h0);
        step("st_rst_hold1", 32'h0);
        rst = 1'b1;
        bus.ir_opcode = 8'h00;
        step("st_restart_F0", 32'h4);

        // HALT, held with run toggling
        bus.ir_opcode = 8'hFF;
        fetch_rest("halt");
        step("halt_word", 32'h8000_0000);
        lit("halt_flag", {31'h0, bus.halted}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            bus.run = i[0];
            step("halt_hold", 32'h8000_0000);
        end

        // Reset leaves HALT
        rst = 1'b0;
        #1;
        lit("halt_rst_flag", {31'h0, bus.halted}, 32'h0);
        tick();
        rst = 1'b1;
        bus.run = 1'b1;
        bus.ir_opcode = 8'h00;
        step("post_halt_F0", 32'h4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 clk  input  1  rising-edge clock; all state and outputs update on posedge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 run  input  1  step enable, sampled each posedge; 0 = insert bubble.
REQ-004 ir_opcode  input  8  current instruction register contents; sampled only in DEC.
REQ-005 acc_neg  input  1  accumulator sign flag; sampled only in A2.
REQ-006 control_signal  output  32  registered one-cycle control word, driven directly from flops.
REQ-007 state_o  output  4  current state encoding, for debug.
REQ-008 halted  output  1  high while in HALT.

Function
REQ-009 Control bit map:
- 0 MEM_WR; 1 PC->MBR; 2 PC->MAR; 3 MBR->PC; 4 MEM_RD (mem->MBR); 5 MBR->IR.
- 6 MBR->MAR; 7 MBR->ACC; 8 ACC->MBR; 9 ACC+=MBR; 10 ACC-=MBR.
- 20 PC_INC; 31 HALT.
- All other bits are 0 at all times.
REQ-010 Opcodes: 0x00 NOP; 0x01 LOAD; 0x02 STORE; 0x03 ADD; 0x04 SUB; 0x05 JMP; 0x06 JMPGEZ; 0xFF HALT. Opcodes 0x01-0x06 are two-byte instructions (opcode, address). Any other value is executed as NOP.
REQ-011 States and words:
- IDLE = 0.
- F0 = bit2; F1 = bit4|bit20; F2 = bit5; DEC = 0.
- A0 = bit2; A1 = bit4|bit20.
- A2: bit3 for JMP and taken JMPGEZ; 0 for not-taken JMPGEZ; bit6 otherwise.
- E0: bit4 for LOAD/ADD/SUB; bit8 for STORE.
- E1: bit7 LOAD; bit9 ADD; bit10 SUB; bit0 STORE.
- HALT = bit31.
REQ-012 Transitions:
- IDLE->F0->F1->F2->DEC.
- DEC: NOP/unknown->F0; HALT->HALT; else->A0.
- A0->A1->A2.
- A2: jump-type->F0; else->E0.
- E0->E1->F0.
- HALT is terminal until reset.
REQ-013 JMPGEZ is taken when acc_neg==0 at A2.
REQ-014 Registered Moore output: at a posedge with run=1, state<=next and control_signal<=word(next), where next is the successor of the current state.
REQ-015 At a posedge with run=0, state holds and control_signal<=0. On resume, sequencing continues from the held state; the held step's word is not re-issued.
REQ-016 In HALT, control_signal stays 0x8000_0000 regardless of run, and halted=1.
REQ-017 Bit 20 is never high on two consecutive cycles, so the level/edge-sensitive PC sees exactly one increment per PC_INC pulse.
REQ-018 At most one of bits {1,3,5,6,7,8} is set per word, and at most one of {0,4}.
REQ-019 Fetch costs 4 cycles. Instruction latency without bubbles: NOP 4; JMP/JMPGEZ 7; LOAD/STORE/ADD/SUB 9 cycles.

Reset
REQ-020 While rst=0: state=IDLE, control_signal=0, state_o=IDLE, halted=0, asynchronously and independent of clk.
REQ-021 Reset asserted mid-instruction aborts the instruction immediately with no further control word. After release, the first posedge with run=1 enters F0.

Verification
REQ-022 Release reset, run=1, ir_opcode=0x00 -> words 0x4, 0x100010, 0x20, 0x0, then repeating from 0x4; bit20 pulses every 4 cycles.
REQ-023 ir_opcode=0x03 (ADD) -> after DEC: 0x4, 0x100010, 0x40, 0x10, 0x200, then F0 word 0x4.
REQ-024 ir_opcode=0x06: acc_neg=0 -> A2 word 0x8; acc_neg=1 -> A2 word 0x0. Both continue to F0 (0x4).
REQ-025 ir_opcode=0xFF -> after DEC, control_signal=0x80000000 and halted=1, held for 20 cycles with run toggling.
REQ-026 run=0 for 3 cycles entering F1 -> three 0x0 words, then 0x100010 exactly once; total bit20 pulses per instruction unchanged.
REQ-027 rst pulsed low during E0 of STORE -> control_signal=0 within the same cycle (no MEM_WR bit0 issued); after release, restarts from F0.
